boa_pwr_seq: RTL and testbench

//   Power/reset sequencer directly downstream of the PMU peripheral; consumes the pmu_bus
//   rst/shdn request pulses. Converts them into a stretched system reset and a timed

---
 rtl/boa_pwr_seq_if.sv | 9 +
 rtl/boa_pwr_seq.sv | 131 +++++++++++++
 tb/tb_boa_pwr_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/boa_pwr_seq_if.sv
// pmu_bus: reset/shutdown request pulses from the PMU peripheral to the power sequencer.
interface pmu_bus;
   logic rst;
   logic shdn;

   modport master (output rst, output shdn);
   modport slave  (input rst, input shdn);
   modport PMU    (input rst, input shdn);
endinterface

// File: rtl/boa_pwr_seq.sv
// boa_pwr_seq: stretched system reset and timed shutdown sequencer, cleared only by board rst.
// Optional wake button path enabled with `define BOA_PWR_SEQ_WAKE_EN.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | system running, sys_rst low, waiting for pmb requests
//   HOLD  | sys_rst held for rst_cycles, then RUN
//   SHDN  | sys_rst held for shdn_cycles, then regulator dropped
//   OFF   | regulator off; exit via board rst (or debounced wake_btn)
module boa_pwr_seq #(
   parameter int rst_cycles  = 16,
   parameter int shdn_cycles = 1024,
   parameter int deb_cycles  = 65536
) (
   input  logic       clk,
   input  logic       rst,
   pmu_bus.PMU        pmb,
   output logic       sys_rst,
   output logic       pwr_en,
   output logic [1:0] state
`ifdef BOA_PWR_SEQ_WAKE_EN
   ,
   input  logic       wake_btn
`endif
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      SHDN = 2'd2,
      OFF  = 2'd3
   } st_t;

   localparam int MAX_RS = (rst_cycles > shdn_cycles) ? rst_cycles : shdn_cycles;
   localparam int MAXC   = (MAX_RS > deb_cycles) ? MAX_RS : deb_cycles;
   localparam int CW     = $clog2(MAXC + 1);

   localparam logic [CW-1:0] RST_TC  = CW'(rst_cycles - 1);
   localparam logic [CW-1:0] SHDN_TC = CW'(shdn_cycles - 1);

   st_t          st;
   logic [CW-1:0] cnt;

   assign state = st;

`ifdef BOA_PWR_SEQ_WAKE_EN
   localparam logic [CW-1:0] DEB_TC = CW'(deb_cycles - 1);

   logic wake_s1;
   logic wake_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         wake_s1 <= 1'b0;
         wake_s2 <= 1'b0;
      end else begin
         wake_s1 <= wake_btn;
         wake_s2 <= wake_s1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= HOLD;
         cnt     <= '0;
         sys_rst <= 1'b1;
         pwr_en  <= 1'b1;
      end else begin
         unique case (st)
            RUN: begin
               // shdn takes priority over a simultaneous rst request
               if (pmb.shdn) begin
                  st      <= SHDN;
                  cnt     <= '0;
                  sys_rst <= 1'b1;
               end else if (pmb.rst) begin
                  st      <= HOLD;
                  cnt     <= '0;
                  sys_rst <= 1'b1;
               end
            end
            HOLD: begin
               if (pmb.shdn) begin
                  st  <= SHDN;
                  cnt <= '0;
               end else if (pmb.rst) begin
                  cnt <= '0;
               end else if (cnt == RST_TC) begin
                  st      <= RUN;
                  cnt     <= '0;
                  sys_rst <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHDN: begin
               // requests are ignored here: a shutdown cannot be cancelled
               if (cnt == SHDN_TC) begin
                  st     <= OFF;
                  cnt    <= '0;
                  pwr_en <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            OFF: begin
`ifdef BOA_PWR_SEQ_WAKE_EN
               if (!wake_s2) begin
                  cnt <= '0;
               end else if (cnt == DEB_TC) begin
                  st      <= HOLD;
                  cnt     <= '0;
                  sys_rst <= 1'b1;
                  pwr_en  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`else
               cnt <= '0;
`endif
            end
            default: begin
               st  <= HOLD;
               cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boa_pwr_seq.sv
// tb_boa_pwr_seq: directed vector table plus hand sequences for the power sequencer.
module tb_boa_pwr_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       sys_rst;
   logic       pwr_en;
   logic [1:0] state;
`ifdef BOA_PWR_SEQ_WAKE_EN
   logic       wake_btn;
`endif

   int checks   = 0;
   int failures = 0;

   pmu_bus pmb ();

   boa_pwr_seq #(
      .rst_cycles (4),
      .shdn_cycles(8),
      .deb_cycles (5)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pmb     (pmb),
      .sys_rst (sys_rst),
      .pwr_en  (pwr_en),
      .state   (state)
`ifdef BOA_PWR_SEQ_WAKE_EN
      ,
      .wake_btn(wake_btn)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       prst;
      logic       pshdn;
      logic [1:0] st;
      logic       sr;
      logic       pe;
   } vec_t;

   vec_t vecs[23];

   task automatic chk(input string name, input logic [1:0] st, input logic sr, input logic pe);
      checks++;
      if (state !== st || sys_rst !== sr || pwr_en !== pe) begin
         failures++;
         $display("FAIL %s: got state=%0d sys_rst=%0b pwr_en=%0b, want state=%0d sys_rst=%0b pwr_en=%0b",
                  name, state, sys_rst, pwr_en, st, sr, pe);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Leaves the bench at the negedge where rst drops: that cycle is cycle 0 of HOLD.
   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      pmb.rst  = 1'b0;
      pmb.shdn = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_state", 2'd1, 1'b1, 1'b1);
      rst = 1'b0;
   endtask

   // Counts sys_rst-high cycles from cycle 0; pulses pmb.rst in cycle pulse_at (-1 for none).
   task automatic count_hold(input int pulse_at, output int n);
      n = 0;
      for (int c = 0; c < 50; c++) begin
         if (c > 0) @(negedge clk);
         pmb.rst = (c == pulse_at);
         if (!sys_rst) break;
         n++;
      end
      pmb.rst = 1'b0;
   endtask

   initial begin
      int n;
      rst      = 1'b1;
      pmb.rst  = 1'b0;
      pmb.shdn = 1'b0;
`ifdef BOA_PWR_SEQ_WAKE_EN
      wake_btn = 1'b0;
`endif

      //            prst  pshdn st    sr    pe
      vecs[0]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
      vecs[16] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1};
      vecs[17] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
      vecs[19] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
      vecs[20] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0};
      vecs[21] = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b0};
      vecs[22] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0};

      // Release, rst pulse at 5, shdn at 11 (OFF from 20), ignored requests in SHDN/OFF
      do_reset();
      for (int i = 0; i < 23; i++) begin
         if (i > 0) @(negedge clk);
         pmb.rst  = vecs[i].prst;
         pmb.shdn = vecs[i].pshdn;
         chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].sr, vecs[i].pe);
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         pmb.rst = (i % 7 == 0);
         chk($sformatf("off_hold%0d", i), 2'd3, 1'b1, 1'b0);
      end
      pmb.rst = 1'b0;

      // Simultaneous rst+shdn in RUN takes the shutdown path
      do_reset();
      repeat (4) @(negedge clk);
      chk("both_run", 2'd0, 1'b0, 1'b1);
      pmb.rst  = 1'b1;
      pmb.shdn = 1'b1;
      @(negedge clk);
      pmb.rst  = 1'b0;
      pmb.shdn = 1'b0;
      chk("both_shdn", 2'd2, 1'b1, 1'b1);
      repeat (7) @(negedge clk);
      chk("both_shdn_last", 2'd2, 1'b1, 1'b1);
      @(negedge clk);
      chk("both_off", 2'd3, 1'b1, 1'b0);

      // pmb.rst in the second HOLD cycle extends the hold to 2+4 cycles
      do_reset();
      count_hold(1, n);
      chk_int("hold_extend_len", n, 6);
      chk("hold_extend_run", 2'd0, 1'b0, 1'b1);

      // Board rst mid-SHDN, then a plain 4-cycle hold
      do_reset();
      repeat (4) @(negedge clk);
      pmb.shdn = 1'b1;
      @(negedge clk);
      pmb.shdn = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_shdn", 2'd2, 1'b1, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_shdn", 2'd1, 1'b1, 1'b1);
      rst = 1'b0;
      count_hold(-1, n);
      chk_int("post_shdn_hold_len", n, 4);

      // pmb.shdn during HOLD goes straight to SHDN
      do_reset();
      pmb.shdn = 1'b1;
      @(negedge clk);
      pmb.shdn = 1'b0;
      chk("shdn_in_hold", 2'd2, 1'b1, 1'b1);

`ifdef BOA_PWR_SEQ_WAKE_EN
      // Wake from OFF: short press ignored, long press powers up
      do_reset();
      repeat (4) @(negedge clk);
      pmb.shdn = 1'b1;
      @(negedge clk);
      pmb.shdn = 1'b0;
      repeat (8) @(negedge clk);
      chk("wake_off", 2'd3, 1'b1, 1'b0);
      wake_btn = 1'b1;
      repeat (3) @(negedge clk);
      wake_btn = 1'b0;
      repeat (10) @(negedge clk);
      chk("wake_short", 2'd3, 1'b1, 1'b0);
      n = -1;
      for (int c = 0; c < 30; c++) begin
         if (c > 0) @(negedge clk);
         wake_btn = 1'b1;
         if (state == 2'd1) begin
            n = c;
            break;
         end
      end
      chk_int("wake_latency", n, 7);
      chk("wake_hold", 2'd1, 1'b1, 1'b1);
      wake_btn = 1'b0;
      repeat (4) @(negedge clk);
      chk("wake_run", 2'd0, 1'b0, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
